// File: rtl/bitstream_decoder_pkg.sv
// Shared definitions for stochastic-to-binary decoders.
//   state_e        : decoder control states.
//   scale_to_fixed : maps a window count 0..2^log_window onto an unsigned
//                    BITWIDTH-bit fraction, saturating at full scale.
package bitstream_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned MAX_BITWIDTH = 63;

  // A count of exactly 2^log_window means 1.0, which is not representable in
  // the unsigned fraction, so it clamps to all ones.
  function automatic logic [MAX_BITWIDTH-1:0] scale_to_fixed(
    input int unsigned mag,
    input int unsigned log_window,
    input int unsigned bitwidth
  );
    logic [MAX_BITWIDTH-1:0] full_scale;
    full_scale = {MAX_BITWIDTH{1'b1}} >> (MAX_BITWIDTH - bitwidth);
    if (mag >= (32'd1 << log_window)) begin
      return full_scale;
    end
    return MAX_BITWIDTH'(mag) << (bitwidth - log_window);
  endfunction

endpackage

// File: rtl/bitstream_accumulator.sv
// Signed up/down counter plus sample counter for one decode window.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the window (priority over in_valid)
//   in_valid  : sample present (already gated by the caller's state)
//   in_p/in_m : positive / negative channel bits
//   acc       : running sum including this cycle's sample
//   last      : this cycle's sample is the final one of the window
module bitstream_accumulator
  import bitstream_decoder_pkg::*;
#(
  parameter int unsigned LOG_WINDOW = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic                         in_p,
  input  logic                         in_m,
  output logic signed [LOG_WINDOW+1:0] acc,
  output logic                         last
);

  localparam int unsigned N = 1 << LOG_WINDOW;

  logic signed [LOG_WINDOW+1:0] acc_q, acc_d, delta;
  logic        [LOG_WINDOW:0]   cnt_q, cnt_d;

  // acc is the look-ahead sum so the caller can latch the result on the same
  // edge that accepts the final sample.
  always_comb begin
    delta = '0;
    if (in_p && !in_m) begin
      delta = (LOG_WINDOW+2)'(1);
    end else if (in_m && !in_p) begin
      delta = '1;
    end

    acc  = in_valid ? acc_q + delta : acc_q;
    last = in_valid && (cnt_q == (LOG_WINDOW+1)'(N - 1));

    acc_d = acc;
    cnt_d = in_valid ? cnt_q + (LOG_WINDOW+1)'(1) : cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bitstream_decoder.sv
// Decodes a signed stochastic bitstream (out_p/out_m pair convention) over a
// window of 2^LOG_WINDOW accepted samples into magnitude + sign.
//   CLK, RST          : clock, synchronous active-high reset
//   start             : begin a window (IDLE, or DONE with handshake)
//   in_valid/in_p/in_m: sample stream, consumed only while busy
//   busy              : accumulating a window
//   out_valid/out_ready: result handshake
//   out_value         : unsigned BITWIDTH-bit fraction, saturated at all ones
//   out_negative      : result sign, never set for zero
module bitstream_decoder
  import bitstream_decoder_pkg::*;
#(
  parameter int unsigned BITWIDTH   = 20,
  parameter int unsigned LOG_WINDOW = 10
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                in_valid,
  input  logic                in_p,
  input  logic                in_m,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_value,
  output logic                out_negative
);

  if (LOG_WINDOW < 1 || LOG_WINDOW > BITWIDTH || BITWIDTH > MAX_BITWIDTH) begin : g_param_check
    $error("bitstream_decoder: LOG_WINDOW must be 1..BITWIDTH and BITWIDTH <= 63");
  end

  state_e                      state_q, state_d;
  logic                        busy_q, busy_d;
  logic                        out_valid_q, out_valid_d;
  logic [BITWIDTH-1:0]         out_value_q, out_value_d;
  logic                        out_negative_q, out_negative_d;

  logic                        acc_clear;
  logic                        acc_valid;
  logic signed [LOG_WINDOW+1:0] acc;
  logic                        acc_last;
  int                          acc_int;
  int unsigned                 mag;

  bitstream_accumulator #(
    .LOG_WINDOW(LOG_WINDOW)
  ) u_accumulator (
    .clk      (CLK),
    .rst      (RST),
    .clear    (acc_clear),
    .in_valid (acc_valid),
    .in_p     (in_p),
    .in_m     (in_m),
    .acc      (acc),
    .last     (acc_last)
  );

  always_comb begin
    state_d        = state_q;
    out_value_d    = out_value_q;
    out_negative_d = out_negative_q;
    acc_clear      = 1'b0;
    acc_valid      = in_valid && (state_q == ACCUM);
    acc_int        = int'(acc);
    mag            = unsigned'(acc_int < 0 ? -acc_int : acc_int);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          acc_clear = 1'b1;
        end
      end
      ACCUM: begin
        if (acc_last) begin
          state_d        = DONE;
          out_value_d    = BITWIDTH'(scale_to_fixed(mag, LOG_WINDOW, BITWIDTH));
          out_negative_d = (acc_int < 0);
        end
      end
      DONE: begin
        // start only counts alongside the handshake: back-to-back window
        if (out_ready) begin
          state_d   = start ? ACCUM : IDLE;
          acc_clear = start;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_value_q    <= '0;
      out_negative_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      out_valid_q    <= out_valid_d;
      out_value_q    <= out_value_d;
      out_negative_q <= out_negative_d;
    end
  end

  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign out_value    = out_value_q;
  assign out_negative = out_negative_q;

endmodule
